banco_registradores: RTL and testbench

- MIPS32 general-purpose register file: 32 x 32-bit registers, two asynchronous read ports, one synchronous write port.
- Sits directly upstream of the ALU. dadoLeitura1 drives entradaA. dadoLeitura2 drives entradaB, directly or via the immediate mux.
- The write port is fed by the writeback path (ALUsaida or memory data).
- Register $0 is hardwired to zero.

---
 rtl/banco_registradores_pkg.sv | 12 +
 rtl/banco_registradores_if.sv | 12 +
 rtl/banco_registradores.sv | 32 +++
 tb/tb_banco_registradores.sv | 132 +++++++++++++
 4 files changed

// File: rtl/banco_registradores_pkg.sv
// banco_registradores_pkg: register-file constants and reset values shared with boot ROM and testbench
package banco_registradores_pkg;
  localparam int NUM_REGS = 32;
  localparam int ENDERECO_W = 5;
  typedef logic [ENDERECO_W-1:0] endereco_t;
  localparam endereco_t REG_ZERO = 5'd0;
  localparam endereco_t REG_GP = 5'd28;
  localparam endereco_t REG_SP = 5'd29;
  localparam endereco_t REG_RA = 5'd31;
  localparam logic [31:0] SP_RESET_DEF = 32'h7FFF_EFFC;
  localparam logic [31:0] GP_RESET_DEF = 32'h1000_8000;
endpackage

// File: rtl/banco_registradores_if.sv
// banco_registradores_if: read/write port bundle between decode/writeback and the register file
interface banco_registradores_if #(parameter int LARGURA = 32);
  logic RegWrite;
  logic [4:0] regLeitura1;
  logic [4:0] regLeitura2;
  logic [4:0] regEscrita;
  logic [LARGURA-1:0] dadoEscrita;
  logic [LARGURA-1:0] dadoLeitura1;
  logic [LARGURA-1:0] dadoLeitura2;
  modport master (output RegWrite, regLeitura1, regLeitura2, regEscrita, dadoEscrita, input dadoLeitura1, dadoLeitura2);
  modport slave (input RegWrite, regLeitura1, regLeitura2, regEscrita, dadoEscrita, output dadoLeitura1, dadoLeitura2);
endinterface

// File: rtl/banco_registradores.sv
// banco_registradores: MIPS32 32x32 register file, 2 async reads, 1 sync write; BANCO_BYPASS_EN enables write-through bypass
module banco_registradores
  import banco_registradores_pkg::*;
#(
  parameter int LARGURA = 32,
  parameter logic [LARGURA-1:0] SP_RESET = SP_RESET_DEF,
  parameter logic [LARGURA-1:0] GP_RESET = GP_RESET_DEF
) (
  input logic clock,
  input logic reset,
  banco_registradores_if.slave bus
);
  logic [LARGURA-1:0] regs [1:NUM_REGS-1];
  function automatic logic [LARGURA-1:0] ler(input endereco_t a);
`ifdef BANCO_BYPASS_EN
    if (!reset && bus.RegWrite && a != REG_ZERO && a == bus.regEscrita) return bus.dadoEscrita;
`endif
    return a == REG_ZERO ? '0 : regs[a];
  endfunction
  // storage: async reset to boot values, then one write per edge; $0 has no storage
  always_ff @(posedge clock or posedge reset)
    if (reset)
      for (int i = 1; i < NUM_REGS; i++)
        regs[i] <= ENDERECO_W'(i) == REG_GP ? GP_RESET : ENDERECO_W'(i) == REG_SP ? SP_RESET : '0;
    else if (bus.RegWrite && bus.regEscrita != REG_ZERO)
      regs[bus.regEscrita] <= bus.dadoEscrita;
  // two independent combinational read ports
  always_comb begin
    bus.dadoLeitura1 = ler(bus.regLeitura1);
    bus.dadoLeitura2 = ler(bus.regLeitura2);
  end
endmodule

// File: tb/tb_banco_registradores.sv
// tb_banco_registradores: directed and random checks against an array model of the register file
module tb_banco_registradores;
  import banco_registradores_pkg::*;
  logic clock = 0;
  logic reset;
  int compared = 0;
  int mism = 0;
  logic [31:0] m [32];
`ifdef BANCO_BYPASS_EN
  localparam bit BYP = 1;
`else
  localparam bit BYP = 0;
`endif
  banco_registradores_if bus ();
  banco_registradores dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m[i] = 32'h0;
    m[28] = GP_RESET_DEF;
    m[29] = SP_RESET_DEF;
  endtask

  function automatic logic [31:0] esperado(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (BYP && !reset && bus.RegWrite && bus.regEscrita == a) return bus.dadoEscrita;
    return m[a];
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    compared++;
    assert (o === e) else begin
      mism++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic rd_chk(input string tag, input logic [4:0] a1, input logic [4:0] a2);
    bus.regLeitura1 = a1;
    bus.regLeitura2 = a2;
    #1;
    chk({tag, "_p1"}, bus.dadoLeitura1, esperado(a1));
    chk({tag, "_p2"}, bus.dadoLeitura2, esperado(a2));
  endtask

  task automatic edge_update();
    @(posedge clock);
    if (!reset && bus.RegWrite && bus.regEscrita != 0) m[bus.regEscrita] = bus.dadoEscrita;
    #1;
  endtask

  task automatic wr(input logic we, input logic [4:0] a, input logic [31:0] d);
    @(negedge clock);
    bus.RegWrite = we;
    bus.regEscrita = a;
    bus.dadoEscrita = d;
    edge_update();
    @(negedge clock);
    bus.RegWrite = 0;
  endtask

  initial begin
    reset = 0;
    bus.RegWrite = 0;
    bus.regEscrita = 0;
    bus.dadoEscrita = 0;
    bus.regLeitura1 = 0;
    bus.regLeitura2 = 0;
    #1 reset = 1;
    model_reset();
    rd_chk("rst0_5", 0, 5);
    rd_chk("rst_gp_sp", 28, 29);
    rd_chk("rst_ra", REG_RA, 29);
    chk("rst_sp_const", bus.dadoLeitura2, 32'h7FFF_EFFC);
    @(negedge clock) reset = 0;
    wr(1, 8, 32'hDEAD_BEEF);
    rd_chk("wr8", 8, 8);
    chk("wr8_const", bus.dadoLeitura1, 32'hDEAD_BEEF);
    wr(1, 0, 32'hFFFF_FFFF);
    rd_chk("r0_prot", 0, 0);
    wr(0, 9, 32'h1234_5678);
    rd_chk("we0_r9", 9, 8);
    chk("we0_const", bus.dadoLeitura1, 32'h0);
    wr(1, 10, 32'h0000_0005);
    @(negedge clock);
    bus.RegWrite = 1;
    bus.regEscrita = 10;
    bus.dadoEscrita = 32'h0000_0007;
    rd_chk("same_pre", 10, 3);
    chk("same_pre_const", bus.dadoLeitura1, BYP ? 32'h7 : 32'h5);
    edge_update();
    rd_chk("same_post", 10, 10);
    chk("same_post_const", bus.dadoLeitura2, 32'h7);
    @(negedge clock) bus.RegWrite = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clock);
      bus.RegWrite = 1'($urandom);
      bus.regEscrita = 5'($urandom);
      bus.dadoEscrita = $urandom;
      rd_chk("rnd", $urandom_range(0, 3) == 0 ? bus.regEscrita : 5'($urandom), 5'($urandom));
      edge_update();
    end
    for (int a = 0; a < 32; a++) rd_chk("sweep", 5'(a), 5'(31 - a));
    @(negedge clock);
    bus.RegWrite = 0;
    #2 reset = 1;
    model_reset();
    rd_chk("mid_rst0_5", 0, 5);
    rd_chk("mid_rst_gp_sp", 28, 29);
    rd_chk("mid_rst_ra", 31, 31);
    @(negedge clock) reset = 0;
    wr(1, 31, 32'h5555_1234);
    rd_chk("ra_set", 31, 31);
    @(negedge clock);
    bus.RegWrite = 1;
    bus.regEscrita = 31;
    bus.dadoEscrita = 32'hAAAA_AAAA;
    #2 reset = 1;
    model_reset();
    rd_chk("rst_wr_during", 31, 29);
    edge_update();
    @(negedge clock);
    reset = 0;
    bus.RegWrite = 0;
    rd_chk("rst_wr_after", 31, 28);
    chk("rst_wr_const", bus.dadoLeitura1, 32'h0);
    wr(1, 31, 32'h0BAD_F00D);
    rd_chk("post_rst_wr", 31, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end
endmodule
